// File: rtl/uart_tx_frame.sv
// UART transmitter: one start bit, DATA_BITS data bits sent LSB first, STOP_BITS stop bits.
// All outputs are registered. A launch is taken only when the registered state is IDLE.
module uart_tx_frame #(
    parameter int CLKS_PER_BIT = 868,
    parameter int DATA_BITS    = 8,
    parameter int STOP_BITS    = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 tx_start,
    input  logic [DATA_BITS-1:0] tx_data,
    output logic                 tx,
    output logic                 tx_busy,
    output logic                 tx_done
);

    localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int BW = $clog2(DATA_BITS);

    localparam logic [CW-1:0] BAUD_LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [BW-1:0] DATA_LAST = BW'(DATA_BITS - 1);
    localparam logic [BW-1:0] STOP_LAST = BW'(STOP_BITS - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_e;

    state_e               state_q, state_d;
    logic [CW-1:0]        baud_q, baud_d;
    logic [BW-1:0]        bit_q, bit_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic                 tx_q, tx_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;
    logic                 bit_end;

    assign bit_end = (baud_q == BAUD_LAST);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            baud_q  <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            tx_q    <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            tx_q    <= tx_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        baud_d  = baud_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        tx_d    = tx_q;
        busy_d  = busy_q;
        done_d  = 1'b0;

        // The baud counter only runs inside a frame and wraps at every bit boundary.
        if (state_q != IDLE) begin
            baud_d = bit_end ? '0 : baud_q + CW'(1);
        end

        case (state_q)
            IDLE: begin
                tx_d   = 1'b1;
                busy_d = 1'b0;
                baud_d = '0;
                bit_d  = '0;
                if (tx_start) begin
                    shift_d = tx_data;
                    state_d = START;
                    busy_d  = 1'b1;
                    tx_d    = 1'b0;
                end
            end
            START: begin
                if (bit_end) begin
                    state_d = DATA;
                    bit_d   = '0;
                    tx_d    = shift_q[0];
                end
            end
            DATA: begin
                if (bit_end) begin
                    if (bit_q == DATA_LAST) begin
                        state_d = STOP;
                        bit_d   = '0;
                        tx_d    = 1'b1;
                    end else begin
                        // Next data bit is presented straight from the pre-shift value.
                        shift_d = shift_q >> 1;
                        bit_d   = bit_q + BW'(1);
                        tx_d    = shift_q[1];
                    end
                end
            end
            STOP: begin
                tx_d = 1'b1;
                if (bit_end) begin
                    if (bit_q == STOP_LAST) begin
                        state_d = IDLE;
                        bit_d   = '0;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                    end else begin
                        bit_d = bit_q + BW'(1);
                    end
                end
            end
            default: begin
                state_d = IDLE;
                tx_d    = 1'b1;
                busy_d  = 1'b0;
            end
        endcase
    end

    assign tx      = tx_q;
    assign tx_busy = busy_q;
    assign tx_done = done_q;

endmodule

// File: tb/tb_uart_tx_frame.sv
// Bench for uart_tx_frame: an 8N1 and an 8N2 instance share one stimulus stream and are
// checked every cycle against a frame-position model, plus literal per-bit frame patterns.
module tb_uart_tx_frame;

  localparam int C  = 4;
  localparam int D  = 8;
  localparam int T1 = (1 + D + 1) * C;
  localparam int T2 = (1 + D + 2) * C;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       tx_start = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic       tx1, busy1, done1;
  logic       tx2, busy2, done2;
  logic       cmp_en = 1'b0;

  int n_cmp = 0;
  int n_bad = 0;

  uart_tx_frame #(.CLKS_PER_BIT(C), .DATA_BITS(D), .STOP_BITS(1)) dut1 (
    .clk(clk), .rst(rst), .tx_start(tx_start), .tx_data(tx_data),
    .tx(tx1), .tx_busy(busy1), .tx_done(done1)
  );

  uart_tx_frame #(.CLKS_PER_BIT(C), .DATA_BITS(D), .STOP_BITS(2)) dut2 (
    .clk(clk), .rst(rst), .tx_start(tx_start), .tx_data(tx_data),
    .tx(tx2), .tx_busy(busy2), .tx_done(done2)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  // Model: each instance is either idle (rem == 0) or rem cycles from the end of its frame.
  // The line level follows from the position inside the frame.
  int         rem1 = 0;
  int         rem2 = 0;
  logic [7:0] dat1 = 8'h00;
  logic [7:0] dat2 = 8'h00;
  logic       mdone1 = 1'b0;
  logic       mdone2 = 1'b0;

  function automatic logic exp_tx(input logic [7:0] d, input int pos);
    int b;
    b = pos / C;
    if (b == 0) return 1'b0;
    if (b <= D) return d[b-1];
    return 1'b1;
  endfunction

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      rem1 = 0; rem2 = 0; mdone1 = 1'b0; mdone2 = 1'b0;
    end else begin
      mdone1 = (rem1 == 1);
      if (rem1 > 0) rem1--;
      else if (tx_start) begin rem1 = T1; dat1 = tx_data; end
      mdone2 = (rem2 == 1);
      if (rem2 > 0) rem2--;
      else if (tx_start) begin rem2 = T2; dat2 = tx_data; end
    end
  end

  // compare process
  always @(negedge clk) begin
    if (cmp_en) begin
      check("model_tx1",   tx1,   (rem1 > 0) ? exp_tx(dat1, T1 - rem1) : 1'b1);
      check("model_busy1", busy1, rem1 > 0);
      check("model_done1", done1, mdone1);
      check("model_tx2",   tx2,   (rem2 > 0) ? exp_tx(dat2, T2 - rem2) : 1'b1);
      check("model_busy2", busy2, rem2 > 0);
      check("model_done2", done2, mdone2);
    end
  end

  // driver tasks
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Returns one cycle after the acceptance edge, i.e. in the first start-bit cycle.
  task automatic pulse(input logic [7:0] d);
    step();
    tx_start = 1'b1;
    tx_data  = d;
    step();
    tx_start = 1'b0;
  endtask

  // Checks a whole frame against literal bit levels (index 0 = start bit) and the done
  // cycle that follows; returns inside the done cycle.
  task automatic check_frame(input int which, input logic [10:0] bits, input int nbits,
                             input int inject);
    for (int cyc = 0; cyc < nbits * C; cyc++) begin
      check($sformatf("frame%0d_tx_c%0d", which, cyc), which ? tx2 : tx1, bits[cyc / C]);
      check($sformatf("frame%0d_busy_c%0d", which, cyc), which ? busy2 : busy1, 1'b1);
      check($sformatf("frame%0d_done_c%0d", which, cyc), which ? done2 : done1, 1'b0);
      if (cyc == inject) begin
        tx_start = 1'b1;
        tx_data  = 8'hFF;
      end else if (cyc == inject + 1) begin
        tx_start = 1'b0;
      end
      step();
    end
    check($sformatf("frame%0d_end_done", which), which ? done2 : done1, 1'b1);
    check($sformatf("frame%0d_end_busy", which), which ? busy2 : busy1, 1'b0);
    check($sformatf("frame%0d_end_tx", which),   which ? tx2 : tx1,     1'b1);
  endtask

  initial begin
    #1;
    rst      = 1'b0;
    cmp_en   = 1'b1;
    tx_start = 1'b1;
    tx_data  = 8'hA5;
    repeat (5) begin
      step();
      check("rst_tx1", tx1, 1'b1);
      check("rst_busy1", busy1, 1'b0);
      check("rst_done1", done1, 1'b0);
      check("rst_busy2", busy2, 1'b0);
    end
    tx_start = 1'b0;
    rst      = 1'b1;
    repeat (10) begin
      step();
      check("idle_tx1", tx1, 1'b1);
      check("idle_busy1", busy1, 1'b0);
      check("idle_busy2", busy2, 1'b0);
    end

    // Single 8'hA5 frame, then 8'h3C launched in its done cycle.
    pulse(8'hA5);
    check_frame(0, 11'b111_0100_1010, 10, -1);
    tx_start = 1'b1;
    tx_data  = 8'h3C;
    step();
    tx_start = 1'b0;
    check_frame(0, 11'b110_0111_1000, 10, -1);
    repeat (10) step();

    // Launch during data bit 2 with new data: frame unchanged, no second frame.
    pulse(8'hA5);
    check_frame(0, 11'b111_0100_1010, 10, 13);
    repeat (50) begin
      step();
      check("no_second_busy1", busy1, 1'b0);
      check("no_second_done1", done1, 1'b0);
    end

    // Reset between edges during data bit 3.
    pulse(8'hA5);
    repeat (17) step();
    #3;
    rst = 1'b0;
    #1;
    check("midrst_tx1", tx1, 1'b1);
    check("midrst_busy1", busy1, 1'b0);
    check("midrst_done1", done1, 1'b0);
    check("midrst_tx2", tx2, 1'b1);
    check("midrst_busy2", busy2, 1'b0);
    step();
    rst = 1'b1;
    repeat (5) begin
      step();
      check("postrst_done1", done1, 1'b0);
      check("postrst_busy1", busy1, 1'b0);
    end
    pulse(8'h01);
    check_frame(0, 11'b110_0000_0010, 10, -1);
    repeat (10) step();

    // Two stop bits on the second instance.
    pulse(8'h80);
    check_frame(1, 11'b111_0000_0000, 11, -1);
    repeat (10) step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
